// File: rtl/alu_seq_ctrl.sv
// Execute-stage sequencer for the 32-bit alu: issue, multiply hold, writeback.
// Define ALU_SEQ_COND_EN to enable condition-code evaluation against flags.
module alu_seq_ctrl #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_opcode,
   input  logic [3:0]       req_cond,
   input  logic             req_s,
   input  logic [4:0]       req_sr_bit,
   input  logic [2:0]       req_sr_cont,
   input  logic [15:0]      req_imm,
   input  logic [3:0]       req_rd,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_opcode,
   output logic [3:0]       alu_cond,
   output logic [4:0]       alu_sr_bit,
   output logic [2:0]       alu_sr_cont,
   output logic             alu_s,
   output logic [15:0]      alu_imm,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [3:0]       alu_flags,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [WIDTH-1:0] wb_data,
   output logic [3:0]       wb_rd,
   output logic             wb_en,
   output logic [3:0]       flags,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL_WAIT, WB} state_t;

   localparam bit         MUL_MULTI = (MUL_LAT > 1);
   localparam logic [3:0] CNT_INIT  = 4'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] rd_q;
   logic       pass;
   logic       capture;
   logic       load_cnt;
   logic       accept;
   logic       is_mul;
   logic       wr_op;
   logic       flag_op;

   assign accept  = (state == IDLE) && req_valid;
   assign is_mul  = (alu_opcode == 4'b0010);
   assign wr_op   = (alu_opcode <= 4'd7) || (alu_opcode == 4'd13);
   assign flag_op = (alu_opcode <= 4'd5);

`ifdef ALU_SEQ_COND_EN
   // flags are {N,Z,C,V}
   always_comb begin
      pass = 1'b0;
      unique case (alu_cond)
         4'h0: pass = 1'b1;
         4'h1: pass = flags[2];
         4'h2: pass = !flags[2];
         4'h3: pass = flags[1];
         4'h4: pass = !flags[1];
         4'h5: pass = flags[3];
         4'h6: pass = !flags[3];
         4'h7: pass = flags[0];
         4'h8: pass = !flags[0];
         4'h9: pass = flags[1] && !flags[2];
         4'ha: pass = !flags[1] || flags[2];
         4'hb: pass = (flags[3] == flags[0]);
         4'hc: pass = (flags[3] != flags[0]);
         4'hd: pass = !flags[2] && (flags[3] == flags[0]);
         4'he: pass = flags[2] || (flags[3] != flags[0]);
         4'hf: pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         alu_cond <= '0;
      else if (accept)
         alu_cond <= req_cond;
   end
`else
   assign pass     = 1'b1;
   assign alu_cond = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      load_cnt = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid)
               state_nx = EXEC;
         end
         EXEC: begin
            if (is_mul && pass && MUL_MULTI) begin
               load_cnt = 1'b1;
               state_nx = MUL_WAIT;
            end else begin
               capture  = 1'b1;
               state_nx = WB;
            end
         end
         MUL_WAIT: begin
            if (cnt == 4'd0) begin
               capture  = 1'b1;
               state_nx = WB;
            end
         end
         WB: begin
            if (wb_ready)
               state_nx = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
      wb_valid  = (state == WB);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_in1     <= '0;
         alu_in2     <= '0;
         alu_opcode  <= '0;
         alu_sr_bit  <= '0;
         alu_sr_cont <= '0;
         alu_s       <= 1'b0;
         alu_imm     <= '0;
         rd_q        <= '0;
         cnt         <= '0;
         wb_data     <= '0;
         wb_rd       <= '0;
         wb_en       <= 1'b0;
         flags       <= '0;
      end else begin
         if (accept) begin
            alu_in1     <= req_a;
            alu_in2     <= req_b;
            alu_opcode  <= req_opcode;
            alu_sr_bit  <= req_sr_bit;
            alu_sr_cont <= req_sr_cont;
            alu_s       <= req_s;
            alu_imm     <= req_imm;
            rd_q        <= req_rd;
         end
         if (load_cnt)
            cnt <= CNT_INIT;
         else if (state == MUL_WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (capture) begin
            wb_data <= alu_out;
            wb_rd   <= rd_q;
            wb_en   <= pass && wr_op;
            if (pass && alu_s && flag_op)
               flags <= alu_flags;
         end
      end
   end

endmodule
